// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_if
// Brief    : CPU-side value/load bus and display-pin bundle for seg7_scan.
// Revision : 1.0
// ============================================================================
interface seg7_scan_if #(
    parameter int DIGITS = 2
) ();
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_en;
    logic                load;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   dig_sel;
    logic                frame_done;

    modport master (
        output value, dp_en, load,
        input  seg, dp, dig_sel, frame_done
    );

    modport slave (
        input  value, dp_en, load,
        output seg, dp, dig_sel, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Time-multiplexed hex 7-segment driver with per-slot ghost
//            blanking and tear-free display update at the frame boundary.
// Revision : 1.0
// ============================================================================
module seg7_scan #(
    parameter int DIGITS       = 2,
    parameter int SCAN_BITS    = 7,
    parameter int BLANK_CYCLES = 4,
    parameter int COMMON_ANODE = 0
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    seg7_scan_if.slave  bus
);

    localparam int                   c_DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_DIG_W-1:0]   c_DIG_LAST = c_DIG_W'(DIGITS - 1);
    localparam logic [SCAN_BITS-1:0] c_PRE_LAST = '1;
    localparam logic [SCAN_BITS-1:0] c_BLANK    = SCAN_BITS'(BLANK_CYCLES);
    localparam logic                 c_INV      = (COMMON_ANODE != 0);

    logic [SCAN_BITS-1:0] r_pre;
    logic [c_DIG_W-1:0]   r_dig;
    logic [4*DIGITS-1:0]  r_shadow_val;
    logic [DIGITS-1:0]    r_shadow_dp;
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [DIGITS-1:0]    r_dig_sel;
    logic                 r_frame_done;

    logic                 w_pre_wrap;
    logic                 w_boundary;
    logic                 w_blank;
    logic [3:0]           w_nibble;
    logic [6:0]           w_hex;
    logic [6:0]           w_seg_log;
    logic                 w_dp_log;
    logic [DIGITS-1:0]    w_sel_log;

    assign w_pre_wrap = (r_pre == c_PRE_LAST);
    assign w_boundary = w_pre_wrap && (r_dig == c_DIG_LAST);
    assign w_blank    = (r_pre < c_BLANK);
    assign w_nibble   = r_disp_val[{r_dig, 2'b00} +: 4];

    // Logical segment pattern, bit order {g,f,e,d,c,b,a}
    always_comb begin
        w_hex = 7'h00;
        case (w_nibble)
            4'h0: w_hex = 7'h3F;
            4'h1: w_hex = 7'h06;
            4'h2: w_hex = 7'h5B;
            4'h3: w_hex = 7'h4F;
            4'h4: w_hex = 7'h66;
            4'h5: w_hex = 7'h6D;
            4'h6: w_hex = 7'h7D;
            4'h7: w_hex = 7'h07;
            4'h8: w_hex = 7'h7F;
            4'h9: w_hex = 7'h6F;
            4'hA: w_hex = 7'h77;
            4'hB: w_hex = 7'h7C;
            4'hC: w_hex = 7'h39;
            4'hD: w_hex = 7'h5E;
            4'hE: w_hex = 7'h79;
            4'hF: w_hex = 7'h71;
            default: w_hex = 7'h00;
        endcase
    end

    // The leading blank cycles of each slot hide segment ghosting on digit switch
    always_comb begin
        w_seg_log = 7'h00;
        w_dp_log  = 1'b0;
        w_sel_log = '0;
        if (!w_blank) begin
            w_seg_log = w_hex;
            w_dp_log  = r_disp_dp[r_dig];
            w_sel_log = DIGITS'(1) << r_dig;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pre        <= '0;
            r_dig        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_seg        <= {7{c_INV}};
            r_dp         <= c_INV;
            r_dig_sel    <= {DIGITS{c_INV}};
            r_frame_done <= 1'b0;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (w_pre_wrap) begin
                r_dig <= (r_dig == c_DIG_LAST) ? '0 : r_dig + 1'b1;
            end
            if (bus.load) begin
                r_shadow_val <= bus.value;
                r_shadow_dp  <= bus.dp_en;
            end
            // A load coincident with the boundary bypasses the shadow so it is not lost for a frame
            if (w_boundary) begin
                r_disp_val <= bus.load ? bus.value : r_shadow_val;
                r_disp_dp  <= bus.load ? bus.dp_en : r_shadow_dp;
            end
            r_seg        <= w_seg_log ^ {7{c_INV}};
            r_dp         <= w_dp_log ^ c_INV;
            r_dig_sel    <= w_sel_log ^ {DIGITS{c_INV}};
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Brief    : Directed bench for seg7_scan (2 digits, 8-cycle slots, 2 blank).
// Revision : 1.0
// ============================================================================
module tb_seg7_scan;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    seg7_scan_if #(.DIGITS(2)) bus_m ();
    seg7_scan_if #(.DIGITS(2)) bus_a ();

    seg7_scan #(
        .DIGITS(2), .SCAN_BITS(3), .BLANK_CYCLES(2), .COMMON_ANODE(0)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    seg7_scan #(
        .DIGITS(2), .SCAN_BITS(3), .BLANK_CYCLES(2), .COMMON_ANODE(1)
    ) u_dut_ca (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk({tag, " seg"},     32'(bus_m.seg),        32'h00);
        chk({tag, " dp"},      32'(bus_m.dp),         32'h0);
        chk({tag, " sel"},     32'(bus_m.dig_sel),    32'h0);
        chk({tag, " fd"},      32'(bus_m.frame_done), 32'h0);
        chk({tag, " ca_seg"},  32'(bus_a.seg),        32'h7F);
        chk({tag, " ca_dp"},   32'(bus_a.dp),         32'h1);
        chk({tag, " ca_sel"},  32'(bus_a.dig_sel),    32'h3);
        chk({tag, " ca_fd"},   32'(bus_a.frame_done), 32'h0);
        reset_n = 1'b1;
    endtask

    // Runs one 16-cycle frame (or its first ncyc cycles). Cycle j's outputs
    // reflect prescaler (j-1)%8 of digit (j-1)/8; frame_done shows at j=16.
    task automatic run_frame(input string tag, input int ncyc,
                             input logic [7:0] ev, input logic [1:0] ed,
                             input int l1, input logic [7:0] v1, input logic [1:0] d1,
                             input int l2, input logic [7:0] v2, input logic [1:0] d2,
                             input bit chk_ca);
        for (int j = 1; j <= ncyc; j++) begin
            int         pre;
            int         dg;
            bit         blank;
            logic [1:0] e_sel;
            logic [6:0] e_seg;
            logic       e_dp;
            string      t;
            if (j == l1) begin
                bus_m.load = 1'b1; bus_m.value = v1; bus_m.dp_en = d1;
            end else if (j == l2) begin
                bus_m.load = 1'b1; bus_m.value = v2; bus_m.dp_en = d2;
            end else begin
                bus_m.load = 1'b0;
            end
            @(posedge clk);
            #1;
            pre   = (j - 1) % 8;
            dg    = (j - 1) / 8;
            blank = (pre < 2);
            e_sel = blank ? 2'b00 : ((dg == 0) ? 2'b01 : 2'b10);
            e_seg = blank ? 7'h00 : hexseg((dg == 0) ? ev[3:0] : ev[7:4]);
            e_dp  = blank ? 1'b0 : ed[dg];
            t = $sformatf("%s[%0d]", tag, j);
            chk({t, " sel"}, 32'(bus_m.dig_sel),    32'(e_sel));
            chk({t, " seg"}, 32'(bus_m.seg),        32'(e_seg));
            chk({t, " dp"},  32'(bus_m.dp),         32'(e_dp));
            chk({t, " fd"},  32'(bus_m.frame_done), 32'(j == 16));
            if (chk_ca) begin
                chk({t, " ca_sel"}, 32'(bus_a.dig_sel),
                    blank ? 32'h3 : ((dg == 0) ? 32'h2 : 32'h1));
                chk({t, " ca_seg"}, 32'(bus_a.seg),
                    blank ? 32'h7F : ((dg == 0) ? 32'h00 : 32'h40));
                chk({t, " ca_dp"},  32'(bus_a.dp), 32'h1);
                chk({t, " ca_fd"},  32'(bus_a.frame_done), 32'(j == 16));
            end
        end
        bus_m.load = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        bus_m.value = '0; bus_m.dp_en = '0; bus_m.load = 1'b0;
        bus_a.value = 8'h08; bus_a.dp_en = '0; bus_a.load = 1'b0;

        // reset then free run: four frames of 00
        do_reset("rst1", 5);
        run_frame("f1", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b0);
        run_frame("f2", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b0);
        run_frame("f3", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b0);
        run_frame("f4", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b0);

        // mid-frame load A5/dp=10 must wait for the boundary
        run_frame("f5", 16, 8'h00, 2'b00, 5, 8'hA5, 2'b10, 0, 8'h00, 2'b00, 1'b0);
        // shows A5; two loads in this frame, last (34) wins
        run_frame("f6", 16, 8'hA5, 2'b10, 3, 8'h12, 2'b00, 9, 8'h34, 2'b00, 1'b0);
        // shows 34; load 7F exactly on the boundary cycle
        run_frame("f7", 16, 8'h34, 2'b00, 16, 8'h7F, 2'b00, 0, 8'h00, 2'b00, 1'b0);
        // shows 7F; load C3 then reset before this frame's boundary
        run_frame("f8", 10, 8'h7F, 2'b00, 5, 8'hC3, 2'b01, 0, 8'h00, 2'b00, 1'b0);
        do_reset("rst2", 3);

        // common-anode instance captures 08 during the first frame after reset
        bus_a.load = 1'b1;
        run_frame("f9", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b0);
        bus_a.load = 1'b0;
        // C3 must have been discarded; CA instance shows 08 inverted
        run_frame("f10", 16, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
